axi_dmem_slave: RTL and testbench
=================================

AXI_DMEM_SLAVE -- requirements
Module: axi_dmem_slave

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 32, address width of all AXI address buses.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, data width; only the value 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words; must be a power of two.
REQ-004 SHALL have ports:
CLK  in  1  system clock, all logic rising-edge.
NRST  in  1  asynchronous active-low reset.
AXI_AWADDR  in  AXI_AWIDTH  write address.
AXI_AWVALID  in  1  write address valid.
AXI_AWREADY  out  1  write address ready.
AXI_WDATA  in  32  write data.
AXI_WSTRB  in  4  byte strobes, bit i enables byte lane i.
AXI_WVALID  in  1  write data valid.
AXI_WREADY  out  1  write data ready.
AXI_BRESP  out  2  write response.
AXI_BVALID  out  1  write response valid.
AXI_BREADY  in  1  write response ready.
AXI_ARADDR  in  AXI_AWIDTH  read address.
AXI_ARVALID  in  1  read address valid.
AXI_ARREADY  out  1  read address ready.
AXI_RDATA  out  32  read data.
AXI_RRESP  out  2  read response.
AXI_RVALID  out  1  read data valid.
AXI_RREADY  in  1  read data ready.

Function
REQ-005 SHALL index words as addr[log2(MEM_DEPTH)+1:2] and ignore addr[1:0].
REQ-006 SHALL run independent write and read paths, with no ordering between them.
REQ-007 Write FSM SHALL have states W_ACCEPT and W_RESP. In W_ACCEPT, AW and W are captured independently, in either order or together.
REQ-008 AWREADY SHALL deassert at the edge of the AW handshake. WREADY SHALL deassert at the edge of the W handshake. Both SHALL reassert at the edge of the B handshake.
REQ-009 At the edge where the second of AW/W is captured (or both together), SHALL write the strobed bytes, go to W_RESP, and drive BVALID=1 from the next cycle.
REQ-010 In W_RESP, BVALID and BRESP SHALL hold until BREADY=1. On the B handshake, BVALID=0 and the FSM returns to W_ACCEPT.
REQ-011 WSTRB=4'b0000 SHALL leave memory unchanged and still return BRESP=OKAY.
REQ-012 Read FSM SHALL have states R_ACCEPT and R_DATA. On the AR handshake, ARREADY=0, and RDATA/RRESP are loaded from the addressed word; RVALID=1 from the next cycle.
REQ-013 In R_DATA, RVALID, RDATA and RRESP SHALL hold until RREADY=1. At the R handshake edge, RVALID=0 and ARREADY=1.
REQ-014 When a write commits and an AR handshakes on the same edge to the same word, the read SHALL return the pre-write data.
REQ-015 Minimum latency SHALL be 1 cycle from handshake to BVALID/RVALID. Peak throughput SHALL be one write and one read per 2 cycles.

Reset
REQ-016 While NRST=0: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, both FSMs in their ACCEPT state, and partial AW/W captures cleared.
REQ-017 AWREADY, WREADY and ARREADY SHALL go to 1 at the first rising edge after NRST deasserts.
REQ-018 Memory contents SHALL NOT be reset. A reset mid-transaction drops the outstanding response; a write already committed persists.

Configuration
REQ-019 Macro DMEM_RANGE_CHECK_EN defined: an address whose bits above addr[log2(MEM_DEPTH)+1] are nonzero is out of range.
- Out-of-range write: memory is not written, BRESP=2'b10 (SLVERR).
- Out-of-range read: RDATA=0, RRESP=2'b10.
REQ-020 Macro undefined: upper address bits are ignored (accesses wrap modulo MEM_DEPTH) and all responses are OKAY.

Structure
REQ-021 AXI_RESP_OKAY (2'b00) and AXI_RESP_SLVERR (2'b10) SHALL live in the shared define.vh; the FSM state encodings stay local.
REQ-022 Storage SHALL be a sub-module axi_dmem_ram:
- four byte-lane arrays;
- one write port with 4-bit byte enable;
- one synchronous read port with read-before-write.

Verification
REQ-023 AW and W in the same cycle, addr 0x10, data 0xDEADBEEF, strb 4'hF, BREADY=1 -> BVALID=1 the next cycle, BRESP=0; then AR 0x10 -> RDATA=0xDEADBEEF one cycle after AR, RRESP=0.
REQ-024 W (0x000000AB, strb 4'b0001) 3 cycles before AW 0x14, word previously 0x11223344 -> no BVALID until AW; read of 0x14 returns 0x112233AB.
REQ-025 BREADY held 0 for 5 cycles and RREADY held 0 for 5 cycles -> BVALID/RVALID, BRESP and RDATA stable; AWREADY/WREADY/ARREADY stay 0 until the respective handshake.
REQ-026 Write of 0x55 to 0x20 and read of 0x20 handshake on the same edge, old value 0x0 -> RDATA=0x0; a subsequent read returns 0x55.
REQ-027 With DMEM_RANGE_CHECK_EN, MEM_DEPTH=1024, write 0xCAFE to 0x1000 -> BRESP=2'b10 and word 0 is unchanged; read 0x1000 -> RDATA=0, RRESP=2'b10. Without the macro, the same write lands in word 0 with BRESP=0.
REQ-028 NRST pulsed low while BVALID=1 -> BVALID=0 immediately; readies=1 one edge after release; the committed data is still readable.

Source files
------------

// File: rtl/axi_dmem_slave_pkg.sv
// Shared constants for the AXI4-Lite data-memory slave.
// Holds the AXI response encodings that the write and read paths return.
package axi_dmem_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int unsigned AXI_DATA_BYTES = 4;

endpackage

// File: rtl/axi_dmem_ram.sv
// Word-addressed storage built from four byte-lane arrays.
// One byte-enabled write port and one registered read port; a read returns the pre-write data.
module axi_dmem_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [3:0][7:0] rd_lane;
  logic [31:0]     rdata_q;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
      if (we_i && be_i[b]) begin
        mem_q[waddr_i] <= wdata_i[8*b +: 8];
      end
    end

    assign rd_lane[b] = mem_q[raddr_i];
  end

  // Contents are never reset; only the output register is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_lane;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_dmem_slave.sv
// AXI4-Lite single-beat data-memory slave with independent write and read paths.
// Define DMEM_RANGE_CHECK_EN to answer SLVERR for addresses beyond MEM_DEPTH instead of wrapping.
module axi_dmem_slave
  import axi_dmem_slave_pkg::*;
#(
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  typedef enum logic {WAccept, WResp} wstate_e;
  typedef enum logic {RAccept, RData} rstate_e;

  wstate_e                  wstate_q, wstate_d;
  logic                     aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [AXI_AWIDTH-1:0]    awaddr_q, awaddr_d;
  logic [AXI_DWIDTH-1:0]    wdata_q, wdata_d;
  logic [AXI_DWIDTH/8-1:0]  wstrb_q, wstrb_d;
  logic                     awready_q, awready_d, wready_q, wready_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;

  rstate_e                  rstate_q, rstate_d;
  logic                     arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]               rresp_q, rresp_d;
  logic                     rd_oor_q, rd_oor_d;

  logic                     aw_fire, w_fire, ar_fire;
  logic [AXI_AWIDTH-1:0]    wr_addr;
  logic [AXI_DWIDTH-1:0]    wr_data;
  logic [AXI_DWIDTH/8-1:0]  wr_strb;
  logic                     wr_oor, rd_oor, ram_we;
  logic [31:0]              ram_rdata;

  assign aw_fire = AXI_AWVALID & awready_q;
  assign w_fire  = AXI_WVALID & wready_q;
  assign ar_fire = AXI_ARVALID & arready_q;

  // A channel captured on an earlier edge takes precedence over the live bus.
  assign wr_addr = aw_got_q ? awaddr_q : AXI_AWADDR;
  assign wr_data = w_got_q  ? wdata_q  : AXI_WDATA;
  assign wr_strb = w_got_q  ? wstrb_q  : AXI_WSTRB;

`ifdef DMEM_RANGE_CHECK_EN
  assign wr_oor = |wr_addr[AXI_AWIDTH-1:IdxW+2];
  assign rd_oor = |AXI_ARADDR[AXI_AWIDTH-1:IdxW+2];
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  always_comb begin
    wstate_d  = wstate_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ram_we    = 1'b0;
    unique case (wstate_q)
      WAccept: begin
        if (aw_fire) begin
          aw_got_d = 1'b1;
          awaddr_d = AXI_AWADDR;
        end
        if (w_fire) begin
          w_got_d = 1'b1;
          wdata_d = AXI_WDATA;
          wstrb_d = AXI_WSTRB;
        end
        if (aw_got_d && w_got_d) begin
          ram_we   = ~wr_oor;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wstate_d = WResp;
          bvalid_d = 1'b1;
          bresp_d  = wr_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
        // Also raises both readies on the first edge out of reset.
        awready_d = (wstate_d == WAccept) && !aw_got_d;
        wready_d  = (wstate_d == WAccept) && !w_got_d;
      end
      WResp: begin
        if (AXI_BREADY) begin
          bvalid_d  = 1'b0;
          wstate_d  = WAccept;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: wstate_d = WAccept;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wstate_q  <= WAccept;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rd_oor_d  = rd_oor_q;
    unique case (rstate_q)
      RAccept: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          rstate_d  = RData;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rd_oor_d  = rd_oor;
          rresp_d   = rd_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
      end
      RData: begin
        if (AXI_RREADY) begin
          rstate_d  = RAccept;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: rstate_d = RAccept;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rstate_q  <= RAccept;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
      rd_oor_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rd_oor_q  <= rd_oor_d;
    end
  end

  axi_dmem_ram #(
    .Depth (MEM_DEPTH),
    .AddrW (IdxW)
  ) u_ram (
    .clk_i   (CLK),
    .rst_ni  (NRST),
    .we_i    (ram_we),
    .be_i    (wr_strb),
    .waddr_i (wr_addr[IdxW+1:2]),
    .wdata_i (wr_data),
    .re_i    (ar_fire),
    .raddr_i (AXI_ARADDR[IdxW+1:2]),
    .rdata_o (ram_rdata)
  );

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_ARREADY = arready_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RRESP   = rresp_q;
  assign AXI_RDATA   = rd_oor_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_axi_dmem_slave.sv
// Randomized scoreboard bench for axi_dmem_slave; expected responses are queued at handshake
// time from a word-array reference model and checked when BVALID/RVALID appear.
module tb_axi_dmem_slave;

  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int IW    = 10;
  localparam int TMO   = 300;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [31:0] AXI_AWADDR = '0;
  logic        AXI_AWVALID = 1'b0;
  logic        AXI_AWREADY;
  logic [31:0] AXI_WDATA = '0;
  logic [3:0]  AXI_WSTRB = '0;
  logic        AXI_WVALID = 1'b0;
  logic        AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID;
  logic        AXI_BREADY = 1'b0;
  logic [31:0] AXI_ARADDR = '0;
  logic        AXI_ARVALID = 1'b0;
  logic        AXI_ARREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID;
  logic        AXI_RREADY = 1'b0;

  always #5 CLK = ~CLK;

  axi_dmem_slave #(
    .AXI_AWIDTH (AW),
    .AXI_DWIDTH (32),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .CLK         (CLK),
    .NRST        (NRST),
    .AXI_AWADDR  (AXI_AWADDR),
    .AXI_AWVALID (AXI_AWVALID),
    .AXI_AWREADY (AXI_AWREADY),
    .AXI_WDATA   (AXI_WDATA),
    .AXI_WSTRB   (AXI_WSTRB),
    .AXI_WVALID  (AXI_WVALID),
    .AXI_WREADY  (AXI_WREADY),
    .AXI_BRESP   (AXI_BRESP),
    .AXI_BVALID  (AXI_BVALID),
    .AXI_BREADY  (AXI_BREADY),
    .AXI_ARADDR  (AXI_ARADDR),
    .AXI_ARVALID (AXI_ARVALID),
    .AXI_ARREADY (AXI_ARREADY),
    .AXI_RDATA   (AXI_RDATA),
    .AXI_RRESP   (AXI_RRESP),
    .AXI_RVALID  (AXI_RVALID),
    .AXI_RREADY  (AXI_RREADY)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one 32-bit word per index, upper address bits wrap or fault.
  logic [31:0] mem_m [DEPTH];

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a[31:IW+2] != '0;
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          c;
  } exp_t;

  exp_t        bq[$];
  exp_t        rq[$];
  bit          m_aw_got = 0, m_w_got = 0;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;

  // Handshakes seen at the negedge complete on the next rising edge.
  always @(negedge CLK) begin : accept_mon
    exp_t e;
    if (NRST) begin
      if (AXI_ARVALID && AXI_ARREADY) begin
        e.c = cyc;
        if (is_oor(AXI_ARADDR)) begin
          e.resp = 2'b10;
          e.data = '0;
        end else begin
          e.resp = 2'b00;
          e.data = mem_m[AXI_ARADDR[IW+1:2]];
        end
        rq.push_back(e);
      end
      if (AXI_AWVALID && AXI_AWREADY) begin
        m_aw_got = 1;
        m_awaddr = AXI_AWADDR;
      end
      if (AXI_WVALID && AXI_WREADY) begin
        m_w_got = 1;
        m_wdata = AXI_WDATA;
        m_wstrb = AXI_WSTRB;
      end
      if (m_aw_got && m_w_got) begin
        e.c    = cyc;
        e.data = '0;
        e.resp = is_oor(m_awaddr) ? 2'b10 : 2'b00;
        if (!is_oor(m_awaddr)) begin
          for (int b = 0; b < 4; b++) begin
            if (m_wstrb[b]) mem_m[m_awaddr[IW+1:2]][8*b +: 8] = m_wdata[8*b +: 8];
          end
        end
        bq.push_back(e);
        m_aw_got = 0;
        m_w_got  = 0;
      end
    end
  end

  bit   b_act = 0, r_act = 0;
  exp_t b_cur, r_cur;

  always @(negedge CLK) begin : b_mon
    if (NRST) begin
      if (AXI_BVALID) begin
        if (!b_act) begin
          if (bq.size() == 0) begin
            check("b_spurious", 64'(AXI_BVALID), 64'd0);
          end else begin
            b_cur = bq.pop_front();
            b_act = 1;
            check("b_latency", 64'(cyc - b_cur.c), 64'd1);
          end
        end
        if (b_act) check("bresp", 64'(AXI_BRESP), 64'(b_cur.resp));
        if (AXI_BREADY) b_act = 0;
      end else if (b_act) begin
        check("bvalid_held", 64'(AXI_BVALID), 64'd1);
        b_act = 0;
      end
    end
  end

  always @(negedge CLK) begin : r_mon
    if (NRST) begin
      if (AXI_RVALID) begin
        if (!r_act) begin
          if (rq.size() == 0) begin
            check("r_spurious", 64'(AXI_RVALID), 64'd0);
          end else begin
            r_cur = rq.pop_front();
            r_act = 1;
            check("r_latency", 64'(cyc - r_cur.c), 64'd1);
          end
        end
        if (r_act) begin
          check("rdata", 64'(AXI_RDATA), 64'(r_cur.data));
          check("rresp", 64'(AXI_RRESP), 64'(r_cur.resp));
        end
        if (AXI_RREADY) r_act = 0;
      end else if (r_act) begin
        check("rvalid_held", 64'(AXI_RVALID), 64'd1);
        r_act = 0;
      end
    end
  end

  // A reset drops every outstanding response and partial capture.
  always @(negedge NRST) begin
    bq.delete();
    rq.delete();
    b_act    = 0;
    r_act    = 0;
    m_aw_got = 0;
    m_w_got  = 0;
  end

  // 0: hold low, 1: hold high, 2: random back-pressure.
  int b_mode = 1;
  int r_mode = 1;
  always @(posedge CLK) begin
    #1;
    AXI_BREADY = (b_mode == 2) ? ($urandom % 3 != 0) : (b_mode == 1);
    AXI_RREADY = (r_mode == 2) ? ($urandom % 3 != 0) : (r_mode == 1);
  end

  // Drivers are entered and left 1 time unit after a rising edge.
  task automatic drive_aw(input logic [31:0] a, input int dly);
    int t = 0;
    if (dly > 0) begin
      repeat (dly) @(posedge CLK);
      #1;
    end
    AXI_AWADDR  = a;
    AXI_AWVALID = 1'b1;
    do begin
      @(negedge CLK);
      t++;
    end while (!AXI_AWREADY && t < TMO);
    check("aw_handshake", 64'(AXI_AWREADY), 64'd1);
    @(posedge CLK);
    #1;
    AXI_AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int t = 0;
    if (dly > 0) begin
      repeat (dly) @(posedge CLK);
      #1;
    end
    AXI_WDATA  = d;
    AXI_WSTRB  = s;
    AXI_WVALID = 1'b1;
    do begin
      @(negedge CLK);
      t++;
    end while (!AXI_WREADY && t < TMO);
    check("w_handshake", 64'(AXI_WREADY), 64'd1);
    @(posedge CLK);
    #1;
    AXI_WVALID = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
  endtask

  task automatic do_read(input logic [31:0] a, input int dly);
    int t = 0;
    if (dly > 0) begin
      repeat (dly) @(posedge CLK);
      #1;
    end
    AXI_ARADDR  = a;
    AXI_ARVALID = 1'b1;
    do begin
      @(negedge CLK);
      t++;
    end while (!AXI_ARREADY && t < TMO);
    check("ar_handshake", 64'(AXI_ARREADY), 64'd1);
    @(posedge CLK);
    #1;
    AXI_ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0 || b_act || r_act) && t < TMO) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("drain_timeout", 64'(t < TMO), 64'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 15) << 2) | ($urandom % 4);
    if ($urandom % 5 == 0) a = a | (32'($urandom_range(1, 15)) << (IW + 2));
    return a;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_awready", 64'(AXI_AWREADY), 64'd0);
    check("rst_wready", 64'(AXI_WREADY), 64'd0);
    check("rst_arready", 64'(AXI_ARREADY), 64'd0);
    check("rst_valids", 64'({AXI_BVALID, AXI_RVALID}), 64'd0);
    check("rst_resps", 64'({AXI_BRESP, AXI_RRESP}), 64'd0);
    check("rst_rdata", 64'(AXI_RDATA), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    NRST = 1'b1;
    @(negedge CLK);
    check("pre_edge_awready", 64'(AXI_AWREADY), 64'd0);
    @(posedge CLK);
    #1;
    check("post_rst_readies", 64'({AXI_AWREADY, AXI_WREADY, AXI_ARREADY}), 64'b111);

    for (int i = 0; i < 16; i++) begin
      do_write(32'(i) << 2, (i == 5) ? 32'h1122_3344 : (i == 8) ? 32'h0 : $urandom, 4'hF, 0, 0);
    end
    wait_idle();

    // AW and W together, then read back.
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    wait_idle();
    do_read(32'h10, 0);
    wait_idle();

    // W three cycles ahead of AW: no response until the address arrives.
    fork
      do_write(32'h14, 32'h0000_00AB, 4'b0001, 3, 0);
      begin
        @(negedge CLK);
        @(negedge CLK);
        check("w_first_wready", 64'(AXI_WREADY), 64'd0);
        check("w_first_awready", 64'(AXI_AWREADY), 64'd1);
        check("w_first_no_b", 64'(AXI_BVALID), 64'd0);
        @(negedge CLK);
        check("w_first_no_b2", 64'(AXI_BVALID), 64'd0);
      end
    join
    wait_idle();
    do_read(32'h14, 0);
    wait_idle();

    // Back-pressure on B then on R.
    b_mode = 0;
    @(posedge CLK);
    #1;
    do_write(32'h18, 32'h0BAD_F00D, 4'hF, 0, 0);
    repeat (5) begin
      @(negedge CLK);
      check("bp_bvalid", 64'(AXI_BVALID), 64'd1);
      check("bp_aw_w_ready", 64'({AXI_AWREADY, AXI_WREADY}), 64'd0);
    end
    b_mode = 1;
    wait_idle();
    r_mode = 0;
    @(posedge CLK);
    #1;
    do_read(32'h18, 0);
    repeat (5) begin
      @(negedge CLK);
      check("bp_rvalid", 64'(AXI_RVALID), 64'd1);
      check("bp_arready", 64'(AXI_ARREADY), 64'd0);
    end
    r_mode = 1;
    wait_idle();

    // Write and read of the same word on the same edge sees the old value.
    fork
      do_write(32'h20, 32'h55, 4'hF, 0, 0);
      do_read(32'h20, 0);
    join
    wait_idle();
    do_read(32'h20, 0);
    wait_idle();

    // Zero strobe and an address beyond MEM_DEPTH.
    do_write(32'h2C, 32'hFFFF_FFFF, 4'h0, 0, 0);
    wait_idle();
    do_read(32'h2C, 0);
    wait_idle();
    do_write(32'h1000, 32'hCAFE, 4'hF, 0, 0);
    wait_idle();
    do_read(32'h0, 0);
    wait_idle();
    do_read(32'h1000, 0);
    wait_idle();

    // Random concurrent traffic with random back-pressure.
    b_mode = 2;
    r_mode = 2;
    fork
      for (int i = 0; i < 80; i++) begin
        do_write(rand_addr(), $urandom, 4'($urandom % 16), $urandom % 3, $urandom % 3);
      end
      for (int i = 0; i < 80; i++) begin
        do_read(rand_addr(), $urandom % 3);
      end
    join
    b_mode = 1;
    r_mode = 1;
    wait_idle();

    // Reset while a write response is pending.
    b_mode = 0;
    @(posedge CLK);
    #1;
    do_write(32'h24, 32'h5A5A_1234, 4'hF, 0, 0);
    @(negedge CLK);
    check("pre_rst_bvalid", 64'(AXI_BVALID), 64'd1);
    @(posedge CLK);
    #1;
    NRST = 1'b0;
    #1;
    check("mid_rst_bvalid", 64'(AXI_BVALID), 64'd0);
    check("mid_rst_readies", 64'({AXI_AWREADY, AXI_WREADY, AXI_ARREADY}), 64'd0);
    check("mid_rst_rdata", 64'(AXI_RDATA), 64'd0);
    b_mode = 1;
    repeat (2) @(posedge CLK);
    #1;
    NRST = 1'b1;
    @(negedge CLK);
    check("rel_pre_edge_readies", 64'({AXI_AWREADY, AXI_WREADY, AXI_ARREADY}), 64'd0);
    @(posedge CLK);
    #1;
    check("rel_readies", 64'({AXI_AWREADY, AXI_WREADY, AXI_ARREADY}), 64'b111);
    do_read(32'h24, 0);
    wait_idle();

    check("b_queue_empty", 64'(bq.size()), 64'd0);
    check("r_queue_empty", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
